text_vram_responder: RTL

//  Responder for the text-mode CSR read port. Holds 16-bit character/attribute cells (bits 7:0 char, 15:8 attr).

---
 rtl/text_vram_pkg.sv | 20 ++
 rtl/text_vram_bram.sv | 37 +++
 rtl/text_vram_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/text_vram_pkg.sv
// text_vram_pkg
//   Shared definitions for the text-mode video RAM responder: the
//   hardware-clear cell value, the CSR read latency and the state
//   encoding of the CPU/clear FSM.
package text_vram_pkg;

    // Space character, light grey on black.
    localparam logic [15:0] BLANK_CELL  = 16'h0720;

    // Cycles from csr_stb_i to valid csr_dat_o.
    localparam int          CSR_LATENCY = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACK   = 2'd2,
        S_CLEAR = 2'd3
    } vram_state_t;

endpackage

// File: rtl/text_vram_bram.sv
// text_vram_bram
//   Single-port 16-bit RAM with per-byte write enables and a registered
//   read port. Read-before-write: q shows the old contents of the address
//   presented in the previous cycle. No reset, so it maps onto block RAM.
// Ports
//   clk   in  1      clock
//   we    in  1      write cycle
//   be    in  2      byte enables: [0]=bits 7:0, [1]=bits 15:8
//   adr   in  ADR_W  word address
//   wdat  in  16     write data
//   q     out 16     read data, one cycle after adr
module text_vram_bram
    import text_vram_pkg::*;
#(
    parameter int ADR_W = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [1:0]       be,
    input  logic [ADR_W-1:0] adr,
    input  logic [15:0]      wdat,
    output logic [15:0]      q
);

    logic [15:0] mem [0:(1 << ADR_W) - 1];

    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem[adr][7:0] <= wdat[7:0];
        end
        if (we && be[1]) begin
            mem[adr][15:8] <= wdat[15:8];
        end
        q <= mem[adr];
    end

endmodule

// File: rtl/text_vram_responder.sv
// text_vram_responder
//   Text-mode character/attribute RAM shared between the display (CSR)
//   reader and a CPU Wishbone slave. One single-port RAM; the display
//   reader always wins the port and is never stalled, CPU cycles wait
//   around it.
//   Optional feature: define TEXT_VRAM_CLEAR_EN to fill the whole RAM with
//   BLANK after every reset before CPU accesses are accepted.
// Ports
//   clk        in  1   system clock
//   rst        in  1   synchronous, active-high reset
//   csr_adr_i  in  16  display word address (low ADR_W bits used)
//   csr_stb_i  in  1   display read strobe, result 2 cycles later
//   csr_dat_o  out 16  display read data, held until the next read
//   wb_adr_i   in  16  CPU word address (low ADR_W bits used)
//   wb_dat_i   in  16  CPU write data
//   wb_dat_o   out 16  CPU read data, valid with wb_ack_o
//   wb_sel_i   in  2   CPU byte enables
//   wb_we_i    in  1   CPU write
//   wb_stb_i   in  1   Wishbone strobe
//   wb_cyc_i   in  1   Wishbone cycle
//   wb_ack_o   out 1   single-cycle acknowledge
module text_vram_responder
    import text_vram_pkg::*;
#(
    parameter int          ADR_W = 11,
    parameter logic [15:0] BLANK = BLANK_CELL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] csr_adr_i,
    input  logic        csr_stb_i,
    output logic [15:0] csr_dat_o,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o
);

`ifdef TEXT_VRAM_CLEAR_EN
    localparam vram_state_t RESET_STATE = S_CLEAR;
`else
    localparam vram_state_t RESET_STATE = S_IDLE;
`endif

    vram_state_t      state, state_nxt;
    logic             issue;
    logic             clearing;
    logic             clr_last;
    logic [ADR_W-1:0] clr_adr;

    logic [ADR_W-1:0] ram_adr;
    logic             ram_we;
    logic [1:0]       ram_be;
    logic [15:0]      ram_wdat;
    logic [15:0]      ram_q;

    logic             cpu_we_p0;
    // One stage between strobe and output: the RAM itself supplies the other.
    logic [CSR_LATENCY-2:0] csr_vld_p0;
    logic [CSR_LATENCY-2:0] csr_blank_p0;

    // Address bits above ADR_W alias onto the same cells.
    logic             unused_adr;
    assign unused_adr = ^{csr_adr_i, wb_adr_i};

`ifdef TEXT_VRAM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_adr <= '0;
        end else if (state == S_CLEAR) begin
            clr_adr <= clr_adr + 1'b1;
        end
    end
    assign clearing = (state == S_CLEAR);
`else
    assign clr_adr  = '0;
    assign clearing = 1'b0;
`endif

    assign clr_last = &clr_adr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // A CPU access is issued only from IDLE, so ACK can never start a
    // second access for the same request.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        wb_ack_o  = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i && !csr_stb_i) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: state_nxt = S_ACK;
            S_ACK: begin
                wb_ack_o  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                if (clr_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Port owner: clear walker, then display reader, then CPU.
    always_comb begin
        ram_adr  = wb_adr_i[ADR_W-1:0];
        ram_we   = 1'b0;
        ram_be   = 2'b00;
        ram_wdat = wb_dat_i;
        if (clearing) begin
            ram_adr  = clr_adr;
            ram_we   = 1'b1;
            ram_be   = 2'b11;
            ram_wdat = BLANK;
        end else if (csr_stb_i) begin
            ram_adr = csr_adr_i[ADR_W-1:0];
        end else if (issue) begin
            ram_we = wb_we_i;
            ram_be = wb_sel_i;
        end
    end

    text_vram_bram #(
        .ADR_W (ADR_W)
    ) u_bram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .adr  (ram_adr),
        .wdat (ram_wdat),
        .q    (ram_q)
    );

    // ---- stage p0: RAM q valid for the access issued one cycle earlier
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_vld_p0   <= '0;
            csr_blank_p0 <= '0;
            cpu_we_p0    <= 1'b0;
            csr_dat_o    <= '0;
            wb_dat_o     <= '0;
        end else begin
            csr_vld_p0   <= csr_stb_i;
            // During clear the port held the walker's address, not the
            // display's, but the cell is (or is about to be) BLANK anyway.
            csr_blank_p0 <= clearing;
            if (issue) begin
                cpu_we_p0 <= wb_we_i;
            end
            if (csr_vld_p0[0]) begin
                csr_dat_o <= csr_blank_p0[0] ? BLANK : ram_q;
            end
            if (state == S_WAIT && !cpu_we_p0) begin
                wb_dat_o <= ram_q;
            end
        end
    end

endmodule
